// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one uart_tx between N_REQ requesters.
// Requesters are served round-robin, and an owner keeps the transmitter
// for a whole frame. Each byte is paced off the transmitter's tx_busy.
module uart_tx_sched #(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ-1:0]   grant,
   output logic [7:0]         tx_data,
   output logic               tx_wr_en,
   input  logic               tx_busy,
   output logic               busy,
   output logic               err
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int SCAN_W = PTR_W + 1;
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
   // The counter starts two cycles after the write pulse, so it times out
   // when it reaches the limit minus those two cycles.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 2);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] gnt_idx;
   logic [PTR_W-1:0] sel_idx;
   logic [PTR_W-1:0] after_gnt;
   logic [SCAN_W-1:0] scan;
   logic [CNT_W-1:0] busy_cnt;
   logic             last_q;
   logic             sel_hit;
   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] sel_onehot;

   // While a frame is in progress only the owner can be chosen.
   assign eligible = (|grant) ? (req & grant) : req;

   // Pointer position just past the current owner, wrapping at N_REQ.
   assign after_gnt = (gnt_idx == PTR_MAX) ? '0 : gnt_idx + PTR_W'(1);

   assign sel_onehot = N_REQ'(1) << sel_idx;

   // Round-robin scan: first eligible requester at or after rr_ptr.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      scan    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan = {1'b0, rr_ptr} + SCAN_W'(k);
         if (scan >= SCAN_W'(N_REQ)) begin
            scan = scan - SCAN_W'(N_REQ);
         end
         if (!sel_hit && eligible[scan[PTR_W-1:0]]) begin
            sel_hit = 1'b1;
            sel_idx = scan[PTR_W-1:0];
         end
      end
   end

   // Scheduler state machine; every output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         ack      <= '0;
         tx_wr_en <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b0;
         last_q   <= 1'b0;
         rr_ptr   <= '0;
         gnt_idx  <= '0;
         busy_cnt <= '0;
         tx_data  <= 8'h00;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (!tx_busy && sel_hit) begin
                  state    <= ISSUE;
                  grant    <= sel_onehot;
                  gnt_idx  <= sel_idx;
                  tx_data  <= req_data[{sel_idx, 3'b000} +: 8];
                  last_q   <= req_last[sel_idx];
                  tx_wr_en <= 1'b1;
                  ack      <= sel_onehot;
                  busy     <= 1'b1;
               end else begin
                  busy <= |grant;
               end
            end
            ISSUE: begin
               tx_wr_en <= 1'b0;
               ack      <= '0;
               busy_cnt <= '0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (busy_cnt == CNT_LAST) begin
                  err    <= 1'b1;
                  grant  <= '0;
                  rr_ptr <= after_gnt;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else begin
                  busy_cnt <= busy_cnt + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  state <= IDLE;
                  if (last_q) begin
                     grant  <= '0;
                     rr_ptr <= after_gnt;
                     busy   <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched with a behavioural uart_tx (clk_en every 4 clk)
// and a scoreboard of expected writes.
module tb_uart_tx_sched;

   localparam int N   = 4;
   localparam int TMO = 7;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   ack;
   logic [N-1:0]   grant;
   logic [7:0]     tx_data;
   logic           tx_wr_en;
   logic           tx_busy;
   logic           busy;
   logic           err;

   int assertCount = 0;
   int failCount = 0;

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic       last;
   } pendT;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } expT;

   pendT pendQ[$];
   expT  sbQ[$];
   logic serialQ[$];

   logic       stuck = 1'b0;
   logic       uActive = 1'b0;
   logic [7:0] uShift = 8'h00;
   int         uPos = 0;
   logic [1:0] divCnt = 2'd0;
   logic       txBusyModel = 1'b0;

   uart_tx_sched #(
      .N_REQ(N),
      .BUSY_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .req_data(req_data),
      .req_last(req_last),
      .ack(ack),
      .grant(grant),
      .tx_data(tx_data),
      .tx_wr_en(tx_wr_en),
      .tx_busy(tx_busy),
      .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expectation and count it.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Drive req/req_data/req_last from the head byte of each requester.
   task automatic refreshReq();
      logic [N-1:0]   r;
      logic [8*N-1:0] d;
      logic [N-1:0]   l;
      r = '0;
      d = '0;
      l = '0;
      foreach (pendQ[k]) begin
         if (!r[pendQ[k].idx]) begin
            r[pendQ[k].idx] = 1'b1;
            d[8*pendQ[k].idx +: 8] = pendQ[k].data;
            l[pendQ[k].idx] = pendQ[k].last;
         end
      end
      req = r;
      req_data = d;
      req_last = l;
   endtask

   // Queue a byte on a requester and record the write it should produce.
   // Calls are made in the order the scheduler is expected to serve them.
   task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last);
      pendT p;
      expT  e;
      p.idx = idx;
      p.data = data;
      p.last = last;
      e.idx = idx;
      e.data = data;
      pendQ.push_back(p);
      sbQ.push_back(e);
      refreshReq();
   endtask

   task automatic popPend(input int idx);
      int found;
      found = -1;
      foreach (pendQ[k]) begin
         if (found < 0 && pendQ[k].idx == idx) found = k;
      end
      if (found >= 0) pendQ.delete(found);
   endtask

   function automatic logic serBit(input logic [7:0] d, input int pos);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return d[pos-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] outVec();
      return 32'({grant, ack, tx_wr_en, err, busy, tx_data});
   endfunction

   // Behavioural uart_tx: registered tx_busy, start + 8 data bits + stop.
   always @(posedge clk) begin
      divCnt <= divCnt + 2'd1;
      txBusyModel <= uActive;
      if (!uActive) begin
         if (tx_wr_en && !stuck) begin
            uActive <= 1'b1;
            uShift <= tx_data;
            uPos <= 0;
         end
      end else if (divCnt == 2'd3) begin
         if (uPos < 10) begin
            serialQ.push_back(serBit(uShift, uPos));
            uPos <= uPos + 1;
         end else begin
            uActive <= 1'b0;
         end
      end
   end

   assign tx_busy = txBusyModel & ~stuck;

   // Scoreboard: each write must match the oldest expected byte and owner.
   always @(negedge clk) begin
      expT e;
      if (tx_wr_en) begin
         checkOutput("sb_pending", 32'(sbQ.size() > 0), 32'd1);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("sb_data", 32'(tx_data), 32'(e.data));
            checkOutput("sb_grant", 32'(grant), 32'(1 << e.idx));
            checkOutput("sb_ack", 32'(ack), 32'(1 << e.idx));
         end
      end
      for (int i = 0; i < N; i++) begin
         if (ack[i]) popPend(i);
      end
      if (|ack) refreshReq();
   end

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitIdle(input string tag);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 1000 && !ok; c++) begin
         @(negedge clk);
         ok = (sbQ.size() == 0) && (pendQ.size() == 0) && !busy && !tx_busy && !uActive;
      end
      checkOutput(tag, 32'(ok), 32'd1);
   endtask

   initial begin
      logic       ok;
      logic [9:0] serWord;
      int         wrCount;
      int         fallAt;
      int         gap;
      logic       prevBusy;
      logic [N-1:0] grantAtFall;
      int         wrAt;
      int         errAt;
      int         errCount;
      logic [N-1:0] grantAtErr;
      logic       busyAtErr;
      logic       sawIdle;
      logic       wrSeen;
      logic       busyAfter;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", outVec(), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_after_reset", outVec(), 32'd0);

      // Single-byte frame
      serialQ.delete();
      applyStimulus(0, 8'hA5, 1'b1);
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         ok = tx_busy;
      end
      checkOutput("single_busy_wait", 32'(ok), 32'd1);
      checkOutput("single_grant_busy", 32'(grant), 32'b0001);
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         ok = !tx_busy;
      end
      checkOutput("single_fall_wait", 32'(ok), 32'd1);
      checkOutput("single_grant_at_fall", 32'(grant), 32'b0001);
      @(negedge clk);
      checkOutput("single_grant_release", 32'(grant), 32'd0);
      checkOutput("single_busy_release", 32'(busy), 32'd0);
      waitIdle("single_idle");
      checkOutput("serial_len", 32'(serialQ.size()), 32'd10);
      serWord = '0;
      foreach (serialQ[k]) serWord = {serWord[8:0], serialQ[k]};
      checkOutput("serial_bits", 32'(serWord), 32'b0101001011);

      // Round-robin from rr_ptr=0: 0,1,2,3 then 0 again after the wrap
      doReset();
      applyStimulus(0, 8'h11, 1'b1);
      applyStimulus(1, 8'h22, 1'b1);
      applyStimulus(2, 8'h33, 1'b1);
      applyStimulus(3, 8'h44, 1'b1);
      applyStimulus(0, 8'h55, 1'b1);
      waitIdle("rr_idle");

      // Frame lock: requester 2 owns three bytes while requester 1 waits
      applyStimulus(2, 8'hC1, 1'b0);
      applyStimulus(2, 8'hC2, 1'b0);
      applyStimulus(2, 8'hC3, 1'b1);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         ok = (grant == 4'b0100);
      end
      checkOutput("lock_grant_wait", 32'(ok), 32'd1);
      applyStimulus(1, 8'hB7, 1'b1);
      waitIdle("lock_idle");

      // Back-to-back bytes of one frame: 2 clk from busy fall to next write
      applyStimulus(0, 8'h81, 1'b0);
      applyStimulus(0, 8'h82, 1'b1);
      wrCount = 0;
      fallAt = -1;
      gap = -1;
      prevBusy = 1'b0;
      grantAtFall = '0;
      for (int c = 0; c < 400 && gap < 0; c++) begin
         @(negedge clk);
         if (tx_wr_en) wrCount++;
         if (wrCount == 1 && prevBusy && !tx_busy && fallAt < 0) begin
            fallAt = c;
            grantAtFall = grant;
         end
         if (wrCount == 2 && gap < 0) gap = c - fallAt;
         prevBusy = tx_busy;
      end
      checkOutput("gap_cycles", 32'(gap), 32'd2);
      checkOutput("gap_grant_held", 32'(grantAtFall), 32'b0001);
      waitIdle("gap_idle");

      // Timeout: tx_busy never rises
      stuck = 1'b1;
      applyStimulus(3, 8'h3C, 1'b1);
      wrAt = -1;
      errAt = -1;
      errCount = 0;
      grantAtErr = '1;
      busyAtErr = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (tx_wr_en && wrAt < 0) wrAt = c;
         if (err) begin
            errCount++;
            if (errAt < 0) begin
               errAt = c;
               grantAtErr = grant;
               busyAtErr = busy;
            end
         end
      end
      checkOutput("tmo_delay", 32'(errAt - wrAt), 32'(TMO));
      checkOutput("tmo_err_pulses", 32'(errCount), 32'd1);
      checkOutput("tmo_grant_clear", 32'(grantAtErr), 32'd0);
      checkOutput("tmo_busy_clear", 32'(busyAtErr), 32'd0);
      waitIdle("tmo_idle");
      stuck = 1'b0;

      // Reset in the middle of a byte; nothing issues until tx_busy drops
      applyStimulus(2, 8'h66, 1'b1);
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         ok = tx_busy;
      end
      checkOutput("mid_busy_wait", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("mid_busy_before_reset", 32'(busy), 32'd1);
      applyStimulus(1, 8'h5A, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("async_reset_outputs", outVec(), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      busyAfter = tx_busy;
      sawIdle = 1'b0;
      wrSeen = 1'b0;
      for (int c = 0; c < 300 && !wrSeen; c++) begin
         @(negedge clk);
         if (tx_wr_en) begin
            wrSeen = 1'b1;
            checkOutput("no_early_write", 32'(sawIdle), 32'd1);
         end
         if (!tx_busy) sawIdle = 1'b1;
      end
      checkOutput("busy_after_reset", 32'(busyAfter), 32'd1);
      checkOutput("reset_wr_wait", 32'(wrSeen), 32'd1);
      waitIdle("reset_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Byte-level scheduler that shares the single `uart_tx` transmitter between `N_REQ` requesters. It arbitrates round-robin, and a grant, once given, is locked for a whole frame (bytes up to and including one flagged `req_last`). It drives the transmitter's `data_input`/`wr_en` and sequences each byte off the transmitter's registered `tx_busy`. It sits between the protocol/response generators and `uart_tx`; baud timing stays in `uart_tx` (`clk_en`).

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 7: cycles to wait for `tx_busy` to rise after a write before flagging an error; must be ≥3.
- `clk` in 1: system clock; same clock as `uart_tx`.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in N_REQ: requester i has a byte ready.
- `req_data` in 8*N_REQ: byte of requester i in bits [8i+7:8i].
- `req_last` in N_REQ: byte of requester i ends its frame.
- `ack` out N_REQ: one-cycle pulse; byte of requester i consumed. The requester may change `req_data`/`req_last` on the next edge.
- `grant` out N_REQ: one-hot owner of the transmitter; zero when unowned.
- `tx_data` out 8: to `uart_tx.data_input`.
- `tx_wr_en` out 1: to `uart_tx.wr_en`; one-cycle pulse.
- `tx_busy` in 1: from `uart_tx.tx_busy`.
- `busy` out 1: high while in any state other than IDLE, or while a grant is held.
- `err` out 1: one-cycle pulse on `tx_busy` timeout.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE. All outputs are registered.
- **IDLE:**
  - Issuing requires `tx_busy`=0.
  - Eligible set: only the granted requester when a grant is held; otherwise all `req` bits.
  - Selection scans from `rr_ptr` upward, modulo N_REQ.
  - On a hit, at the same edge: go to ISSUE; `grant` is set one-hot; `tx_data` takes the selected byte; `last_q` takes its `req_last`; `tx_wr_en` goes to 1; `ack[i]` goes to 1.
- **ISSUE:** lasts one cycle. `uart_tx` captures `tx_data` at the edge that ends it. At that edge `tx_wr_en` and `ack` clear, the timeout counter clears, and the state goes to WAIT_BUSY.
- **WAIT_BUSY:**
  - `tx_busy`=1: go to WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT: pulse `err`, clear `grant`, advance `rr_ptr`, go to IDLE.
- **WAIT_DONE:** stay until `tx_busy`=0, then go to IDLE.
  - If `last_q`=1: clear `grant` and set `rr_ptr` to granted index+1 (mod N_REQ).
  - Otherwise keep `grant`.
- **Grant lock:** while a grant is held, other requesters are starved. If the owner drops `req` mid-frame, the scheduler waits with the grant held (by requirement, requesters complete their frames).
- **Simultaneous requests:** the lowest index at or after `rr_ptr` wins. `req` on a non-owner during a frame is ignored until release.
- **`rr_ptr`:** ⌈log2 N_REQ⌉ bits, wraps from N_REQ-1 to 0.
- **Reset:**
  - Asynchronous.
  - State goes to IDLE; `grant`, `ack`, `tx_wr_en`, `err`, `busy`, `last_q`, `rr_ptr` and the counter go to 0; `tx_data` goes to 8'h00.
  - `uart_tx` has no reset. After reset the scheduler issues nothing until it samples `tx_busy`=0, so a byte in flight finishes undisturbed.

## Timing
- Request sampled at edge E0 (IDLE, `tx_busy`=0): `tx_wr_en`/`ack` are high from E0 to E1.
- `uart_tx` enters START at E1; `tx_busy`=1 is visible after E2; WAIT_BUSY exits at E3.
- Minimum WAIT_BUSY residence is 2 cycles, so BUSY_TIMEOUT ≥3.
- Once a byte completes, `tx_busy` falls, WAIT_DONE exits at the next edge, and the following byte can issue one edge later. Back-to-back frame bytes therefore add 2 clk of gap beyond the uart_tx stop bit.
- `ack` and `tx_wr_en` are always coincident and never high for 2 consecutive cycles.
- `grant` changes only at the IDLE→ISSUE edge (set) or on release/timeout (clear).

## Test plan
- **Single-byte frame:** `req[0]`=1, `req_data`[7:0]=8'hA5, `req_last[0]`=1, with a uart_tx model using `clk_en` every 4 clk.
  - One `tx_wr_en` pulse with `tx_data`=8'hA5, coincident `ack[0]`.
  - `grant`=4'b0001 until `tx_busy` falls, then 0.
  - Serial line shows 0,1,0,1,0,0,1,0,1,1.
- **Round-robin:** `req`=4'b1111, all frames one byte.
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - `rr_ptr` wraps after index 3.
- **Frame lock:** requester 2 sends 3 bytes (last on the 3rd) while `req[1]` is held high.
  - Three consecutive `ack[2]` pulses, none on `ack[1]`.
  - Then `grant`=4'b0010 once `tx_busy` falls. Because `rr_ptr`=3 after requester 2's frame and `req[3]` is low, the scan wraps 3→0→1 and reaches requester 1.
- **Timeout:** tie `tx_busy`=0 and request 8'h3C.
  - `err` pulses exactly once, BUSY_TIMEOUT cycles after the `tx_wr_en` cycle.
  - `grant` clears and `busy`=0.
- **Reset mid-byte:** assert `rst` during WAIT_DONE while `tx_busy`=1.
  - All outputs are 0 immediately (asynchronously).
  - After `rst` falls with `req[1]`=1, no `tx_wr_en` occurs until `tx_busy`=0 is sampled; then `grant`=4'b0010.
- **Back-to-back gap:** two bytes from requester 0.
  - The second `tx_wr_en` rises exactly 2 clk after the first `tx_busy` fall is sampled.
